video_scanout: RTL and testbench
================================

// Module: video_scanout
// PURPOSE
//  Raster timing generator and pixel fetcher for the video SRAM read port. Produces hsync/vsync/blank,
//  drives the byte address of the read-only video port, unpacks 32-bit words into 4-bit pixel
//  indices and replicates each source pixel 2^H_SCALE_LOG2 x 2^V_SCALE_LOG2 times. Output feeds the
//  palette/DAC stage. Runs on the video clock; the SRAM read port is clocked by the same clk.
// PARAMETERS
//  H_VISIBLE 640 | H_FRONT 16 | H_SYNC 96 | H_BACK 48    horizontal timing, pixel clocks
//  V_VISIBLE 480 | V_FRONT 10 | V_SYNC 2  | V_BACK 33    vertical timing, lines
//  H_SCALE_LOG2 3   log2 horizontal repeat of a source pixel (80 source px/line)
//  V_SCALE_LOG2 3   log2 vertical repeat of a source line (60 source lines)
//  ADDR_WIDTH   12  byte address width of the video port
// PORTS
//  clk            in   1   video pixel clock, single clock domain
//  rst            in   1   synchronous reset, ACTIVE-LOW (0 = reset)
//  enable         in   1   1 = scan out; 0 = counters held at 0, blank=1, syncs inactive
//  base_address   in   12  frame start byte address (word aligned, [1:0] ignored)
//  video_address  out  12  byte address to video SRAM read port, registered, [1:0] always 0
//  video_data     in   32  read word; valid 2 clk edges after video_address changes
//  pixel          out  4   pixel index, pixel[0] of word = bits [3:0], LSB nibble first
//  blank          out  1   1 outside visible area
//  hsync          out  1   active-low horizontal sync
//  vsync          out  1   active-low vertical sync
// BEHAVIOUR
//  Reset (rst=0 at edge): h_count=v_count=0, video_address=0, pixel=0, blank=1, hsync=vsync=1,
//   shift/holding registers 0, line_address=0. Reset mid-frame restarts frame at h=0,v=0 next cycle.
//  Counters: h_count 0..H_TOTAL-1 (H_TOTAL=sum of H_*), wraps to 0 and increments v_count;
//   v_count 0..V_TOTAL-1 wraps to 0. Visible region h<H_VISIBLE && v<V_VISIBLE; order is
//   visible, front porch, sync, back porch.
//  Outputs registered: pixel/blank/hsync/vsync at edge N reflect counters of cycle N-1, all aligned.
//   hsync=0 for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC; vsync likewise on v_count.
//   pixel=0 whenever blank=1.
//  Words: one word = 8 source px = 8<<H_SCALE_LOG2 screen px (span). Row = H_VISIBLE>>H_SCALE_LOG2
//   source px = ROW_BYTES = (H_VISIBLE>>H_SCALE_LOG2)/2 bytes; must be a multiple of 4.
//  Fetch pipeline: holding register next_word, shift register cur_word.
//   - Address for span k of the line issued 4 cycles before span k starts (span 0: at h=H_TOTAL-4
//     of previous line, or of last line for v=0); video_data captured into next_word 2 edges later.
//   - At span start cur_word<=next_word; every 2^H_SCALE_LOG2 visible pixels cur_word>>=4.
//   - After last span of a visible line no further fetch until next line prefetch.
//  Line address: latched line_address<=base_address at h=H_TOTAL-5,v=V_TOTAL-1 (base change only
//   takes effect at frame boundary). After each visible line whose v[V_SCALE_LOG2-1:0] is all ones,
//   line_address+=ROW_BYTES; otherwise same row refetched. Address arithmetic wraps mod 2^ADDR_WIDTH.
//  video_address = line_address + 4*k during fetch; holds last value otherwise.
//  enable: sampled each cycle; 0 behaves as reset of counters/outputs but keeps video_address;
//   rising enable starts at h=0,v=0 with first row at base_address (first line pixels = 0 because no
//   prefetch occurred; lines from v=1 correct).
//  Simultaneous: rst=0 dominates enable; base_address change mid-frame ignored until latch point.
// TESTING
//  Tests use H 16/2/2/4, V 4/1/1/2, H_SCALE_LOG2=1, V_SCALE_LOG2=1 (ROW_BYTES=4, 1 span/line).
//  1 Reset: rst=0 3 cycles -> blank=1,hsync=vsync=1,pixel=0,video_address=0; release -> h counts 0..23.
//  2 Timing: hsync low exactly 2 clks starting h=18 (+1 reg), period 24; vsync low for line 5 only,
//    frame period 8*24=192 clks.
//  3 Pixels: SRAM model word@0x000=0x76543210 -> visible line pixels 0,0,1,1,2,2..7,7 with blank=0.
//  4 Vertical scale: words @0x000=0x11111111, @0x004=0x22222222 -> lines 0,1 pixel=1; lines 2,3
//    pixel=2; video_address sequence per frame 0x000,0x000,0x004,0x004.
//  5 Base latch: base_address 0x000->0x100 mid-frame -> current frame unchanged, next frame first
//    fetch 0x100; address wrap: base 0xFFC -> second row fetch at 0x000.
//  6 Disruption: rst=0 mid visible line -> outputs reset next edge; enable=0 2 cycles -> blank=1,
//    counters 0, restart at h=0,v=0 on enable=1.

Source files
------------

// File: rtl/video_scanout.sv
// Raster timing generator and pixel fetcher for the video SRAM read port.
// Unpacks 32-bit words into 4-bit pixels with horizontal/vertical replication.
module video_scanout #(
    parameter int H_VISIBLE    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_VISIBLE    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter int H_SCALE_LOG2 = 3,
    parameter int V_SCALE_LOG2 = 3,
    parameter int ADDR_WIDTH   = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] base_address,
    output logic [ADDR_WIDTH-1:0] video_address,
    input  logic [31:0]           video_data,
    output logic [3:0]            pixel,
    output logic                  blank,
    output logic                  hsync,
    output logic                  vsync
);

    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW        = $clog2(H_TOTAL);
    localparam int VW        = $clog2(V_TOTAL);
    localparam int SPAN_LOG2 = 3 + H_SCALE_LOG2;
    localparam int ROW_BYTES = (H_VISIBLE >> H_SCALE_LOG2) / 2;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_PRE     = HW'(H_TOTAL - 4);
    localparam logic [HW-1:0] H_LATCH   = HW'(H_TOTAL - 5);
    localparam logic [HW-1:0] H_VIS     = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SS      = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SE      = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] SPAN_MASK = HW'((1 << SPAN_LOG2) - 1);
    localparam logic [HW-1:0] REP_MASK  = HW'((1 << H_SCALE_LOG2) - 1);
    localparam logic [HW:0]   AHEAD_MSK = (HW+1)'((1 << SPAN_LOG2) - 1);
    localparam logic [HW:0]   H_VIS_X   = (HW+1)'(H_VISIBLE);

    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS   = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SS    = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SE    = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] VS_MASK = VW'((1 << V_SCALE_LOG2) - 1);

    localparam logic [ADDR_WIDTH-1:0] ROW_B = ADDR_WIDTH'(ROW_BYTES);

    logic [HW-1:0]         h_q, h_d;
    logic [VW-1:0]         v_q, v_d;
    logic [ADDR_WIDTH-1:0] video_address_q, video_address_d;
    logic [ADDR_WIDTH-1:0] line_addr_q, line_addr_d;
    logic [31:0]           next_word_q, next_word_d;
    logic [31:0]           cur_word_q, cur_word_d;
    logic [1:0]            fetch_q, fetch_d;
    logic [3:0]            pixel_q, pixel_d;
    logic                  blank_q, blank_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;

    logic                  vis;
    logic [VW-1:0]         v_next;
    logic                  fetch_pre;
    logic                  fetch_mid;
    logic                  do_latch;
    logic                  do_inc;
    logic                  span_start;
    logic                  rep_last;
    logic [HW:0]           h_ahead;
    logic [ADDR_WIDTH-1:0] span_off;
    logic [ADDR_WIDTH-1:0] base_al;
    logic [31:0]           word_src;

    always_comb begin
        vis        = (h_q < H_VIS) && (v_q < V_VIS);
        v_next     = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        h_ahead    = {1'b0, h_q} + (HW+1)'(4);
        span_off   = ADDR_WIDTH'(h_ahead >> SPAN_LOG2) << 2;
        base_al    = {base_address[ADDR_WIDTH-1:2], 2'b00};
        span_start = (h_q & SPAN_MASK) == '0;
        rep_last   = (h_q & REP_MASK) == REP_MASK;
        word_src   = span_start ? next_word_q : cur_word_q;
        // Span 0 is fetched at the tail of the preceding line; later spans 4 clks ahead.
        fetch_pre  = (h_q == H_PRE) && (v_next < V_VIS);
        fetch_mid  = (v_q < V_VIS) && ((h_ahead & AHEAD_MSK) == '0)
                     && (h_ahead < H_VIS_X);
        do_latch   = (h_q == H_LATCH) && (v_q == V_LAST);
        do_inc     = (h_q == H_LATCH) && (v_q < V_VIS)
                     && ((v_q & VS_MASK) == VS_MASK);
    end

    always_comb begin
        h_d             = h_q;
        v_d             = v_q;
        video_address_d = video_address_q;
        line_addr_d     = line_addr_q;
        next_word_d     = next_word_q;
        cur_word_d      = cur_word_q;
        fetch_d         = fetch_q;
        pixel_d         = 4'h0;
        blank_d         = 1'b1;
        hsync_d         = 1'b1;
        vsync_d         = 1'b1;
        if (!enable) begin
            h_d         = '0;
            v_d         = '0;
            line_addr_d = base_al;
            next_word_d = '0;
            cur_word_d  = '0;
            fetch_d     = '0;
        end else begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = v_next;
            end else begin
                h_d = h_q + HW'(1);
            end
            blank_d = !vis;
            hsync_d = !((h_q >= H_SS) && (h_q < H_SE));
            vsync_d = !((v_q >= V_SS) && (v_q < V_SE));
            if (vis) begin
                pixel_d    = word_src[3:0];
                cur_word_d = rep_last ? (word_src >> 4) : word_src;
            end
            fetch_d = {fetch_q[0], fetch_pre | fetch_mid};
            if (fetch_q[1]) next_word_d = video_data;
            if (fetch_pre) begin
                video_address_d = line_addr_q;
            end else if (fetch_mid) begin
                video_address_d = line_addr_q + span_off;
            end
            if (do_latch) begin
                line_addr_d = base_al;
            end else if (do_inc) begin
                line_addr_d = line_addr_q + ROW_B;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q             <= '0;
            v_q             <= '0;
            video_address_q <= '0;
            line_addr_q     <= '0;
            next_word_q     <= '0;
            cur_word_q      <= '0;
            fetch_q         <= '0;
            pixel_q         <= '0;
            blank_q         <= 1'b1;
            hsync_q         <= 1'b1;
            vsync_q         <= 1'b1;
        end else begin
            h_q             <= h_d;
            v_q             <= v_d;
            video_address_q <= video_address_d;
            line_addr_q     <= line_addr_d;
            next_word_q     <= next_word_d;
            cur_word_q      <= cur_word_d;
            fetch_q         <= fetch_d;
            pixel_q         <= pixel_d;
            blank_q         <= blank_d;
            hsync_q         <= hsync_d;
            vsync_q         <= vsync_d;
        end
    end

    assign video_address = video_address_q;
    assign pixel         = pixel_q;
    assign blank         = blank_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;

endmodule

// File: tb/tb_video_scanout.sv
// Bench for video_scanout: small raster, SRAM model, frame-level reference model.
// Expected outputs come from raster position, frame base and memory contents.
`timescale 1ns/1ps
module tb_video_scanout;

    localparam int HV = 16, HF = 2, HSY = 2, HB = 4;
    localparam int VV = 4, VF = 1, VSY = 1, VB = 2;
    localparam int HSC = 1, VSC = 1;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int SPAN = 8 << HSC;
    localparam int ROWB = (HV >> HSC) / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [11:0] base_address = 12'h000;
    logic [11:0] video_address;
    logic [31:0] video_data;
    logic [3:0]  pixel;
    logic        blank, hsync, vsync;

    logic [31:0] mem [0:1023];

    video_scanout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .H_SCALE_LOG2(HSC), .V_SCALE_LOG2(VSC), .ADDR_WIDTH(12)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .base_address(base_address), .video_address(video_address),
        .video_data(video_data), .pixel(pixel),
        .blank(blank), .hsync(hsync), .vsync(vsync)
    );

    always #5 clk = ~clk;

    // Read port: address sampled on one edge, data visible until the next.
    always @(posedge clk) video_data <= mem[video_address[11:2]];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference state: raster position, frame base, last expected address.
    int          mh = 0, mv = 0;
    logic [11:0] m_fb = 12'h000;
    logic [11:0] m_addr = 12'h000;
    bit          m_rs = 1'b1;
    logic        e_blank, e_hs, e_vs;
    logic [3:0]  e_pix;

    int cyc = 0;
    bit meas = 1'b0;
    int hs_fall = -1, vs_fall = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b1;

    function automatic logic [11:0] row_addr(int v);
        logic [11:0] off;
        off = 12'((v >> VSC) * ROWB);
        return m_fb + off;
    endfunction

    function automatic logic [3:0] src_pixel(int h, int v);
        int          sp;
        logic [11:0] a;
        logic [31:0] w;
        sp = h >> HSC;
        a  = row_addr(v) + 12'(4 * (sp / 8));
        w  = mem[a[11:2]];
        return w[4 * (sp % 8) +: 4];
    endfunction

    task automatic step();
        bit vis;
        int nv;
        if (!rst) begin
            e_blank = 1'b1; e_hs = 1'b1; e_vs = 1'b1; e_pix = 4'h0;
            m_addr = 12'h000; m_fb = 12'h000;
            mh = 0; mv = 0; m_rs = 1'b1;
        end else if (!enable) begin
            e_blank = 1'b1; e_hs = 1'b1; e_vs = 1'b1; e_pix = 4'h0;
            m_fb = base_address & 12'hFFC;
            mh = 0; mv = 0; m_rs = 1'b1;
        end else begin
            vis     = (mh < HV) && (mv < VV);
            e_blank = !vis;
            e_hs    = !((mh >= HV + HF) && (mh < HV + HF + HSY));
            e_vs    = !((mv >= VV + VF) && (mv < VV + VF + VSY));
            if (!vis) e_pix = 4'h0;
            else if (m_rs && mv == 0 && mh < SPAN) e_pix = 4'h0;
            else e_pix = src_pixel(mh, mv);
            nv = (mv + 1) % VT;
            if (mh == HT - 5 && mv == VT - 1) m_fb = base_address & 12'hFFC;
            if (mh == HT - 4) begin
                if (nv < VV) m_addr = row_addr(nv);
                m_rs = 1'b0;
            end else if (mv < VV && (mh + 4) % SPAN == 0 && mh + 4 < HV) begin
                m_addr = row_addr(mv) + 12'(4 * ((mh + 4) / SPAN));
            end
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = nv;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("blank", 32'(blank), 32'(e_blank));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("pixel", 32'(pixel), 32'(e_pix));
        chk("vaddr", 32'(video_address), 32'(m_addr));
        if (meas && prev_hs && !hsync) begin
            if (hs_fall >= 0) chk("hs_period", 32'(cyc - hs_fall), 32'(HT));
            hs_fall = cyc;
        end
        if (meas && prev_vs && !vsync) begin
            if (vs_fall >= 0) chk("vs_period", 32'(cyc - vs_fall), 32'(HT * VT));
            vs_fall = cyc;
        end
        prev_hs = hsync;
        prev_vs = vsync;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h76543210;

        // Reset with enable high: reset dominates.
        rst = 1'b0; enable = 1'b1; base_address = 12'h000;
        run(3);
        chk("rst_vaddr", 32'(video_address), 32'h0);
        chk("rst_blank", 32'(blank), 32'h1);
        chk("rst_pixel", 32'(pixel), 32'h0);

        // Timing and unpacking of 0x76543210.
        rst = 1'b1; meas = 1'b1;
        run(3 * HT * VT);
        meas = 1'b0;

        // Vertical replication across two rows.
        enable = 1'b0;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        run(2);
        enable = 1'b1;
        run(2 * HT * VT);

        // Base change mid-frame, then wrap from 0xFFC.
        run(50);
        base_address = 12'h100;
        run(2 * HT * VT);
        base_address = 12'hFFC;
        run(2 * HT * VT);

        // Reset in the middle of a visible line.
        for (int i = 0; i < 400 && !(mh == 8 && mv < VV); i++) step();
        chk("reach_mid", 32'(mh == 8 && mv < VV), 32'h1);
        rst = 1'b0;
        run(1);
        chk("midrst_blank", 32'(blank), 32'h1);
        chk("midrst_vaddr", 32'(video_address), 32'h0);
        rst = 1'b1;
        run(100);

        // Enable dropped for two cycles.
        enable = 1'b0;
        run(2);
        chk("dis_blank", 32'(blank), 32'h1);
        chk("dis_hsync", 32'(hsync), 32'h1);
        enable = 1'b1;
        run(2 * HT * VT);

        // Randomised disruptions, base changes and memory refresh.
        for (int i = 0; i < 6000; i++) begin
            rst    = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
            enable = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 99) < 2) base_address = 12'($urandom);
            if (!rst || !enable) begin
                for (int j = 0; j < 16; j++) mem[$urandom_range(0, 1023)] = $urandom;
            end
            step();
        end
        rst = 1'b1;
        enable = 1'b1;
        run(2 * HT * VT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
